serial_cmp: RTL

SERIAL_CMP -- requirements
Module: serial_cmp

---
 rtl/cmp_pkg.sv | 32 +++
 rtl/cmp_bit_cell.sv | 28 ++
 rtl/serial_cmp.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// Holds the FSM state encoding and the one-hot cascade constants.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One-hot comparison/cascade word, MSB = less-than.
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } casc_t;

  localparam casc_t CASC_LT = 3'b100;
  localparam casc_t CASC_EQ = 3'b010;
  localparam casc_t CASC_GT = 3'b001;

  // Reduce an arbitrary cascade input to one-hot: lt wins over gt, gt over eq,
  // and an all-zero input means "more-significant words were equal".
  function automatic casc_t normalise_casc(input logic lt, input logic eq,
                                           input logic gt);
    if (lt)      return CASC_LT;
    else if (gt) return CASC_GT;
    else if (eq) return CASC_EQ;
    else         return CASC_EQ;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Single-bit comparator cell: refines an eq cascade with one operand bit pair,
// and passes a decided (lt or gt) cascade through unchanged.
module cmp_bit_cell
  import cmp_pkg::*;
(
  input  logic a_bit,
  input  logic b_bit,
  input  logic lt_i,
  input  logic eq_i,
  input  logic gt_i,
  output logic lt_o,
  output logic eq_o,
  output logic gt_o
);

  // Decide the next cascade state from the current one and this bit pair.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    {lt_o, eq_o, gt_o} = {lt_i, eq_i, gt_i};
    if (eq_i) begin
      if (a_bit && !b_bit)      {lt_o, eq_o, gt_o} = CASC_GT;
      else if (!a_bit && b_bit) {lt_o, eq_o, gt_o} = CASC_LT;
      else                      {lt_o, eq_o, gt_o} = CASC_EQ;
    end
  end

endmodule

// File: rtl/serial_cmp.sv
// Bit-serial cascadable magnitude comparator, MSB first, one bit per clock.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: leave SHIFT as soon as the result
// is decided instead of always walking all WIDTH bits.
module serial_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             lt_in,
  input  logic             eq_in,
  input  logic             gt_in,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             a_gt_b
);

  // Counter holds 0..WIDTH so it can never wrap within one comparison.
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  casc_t            casc_q, casc_d;
  casc_t            res_q, res_d;
  casc_t            cell_nxt;
  logic             leave_shift;

  cmp_bit_cell u_cell (
    .a_bit (a_sh_q[WIDTH-1]),
    .b_bit (b_sh_q[WIDTH-1]),
    .lt_i  (casc_q.lt),
    .eq_i  (casc_q.eq),
    .gt_i  (casc_q.gt),
    .lt_o  (cell_nxt.lt),
    .eq_o  (cell_nxt.eq),
    .gt_o  (cell_nxt.gt)
  );

  // Exit SHIFT after the last bit, or as soon as the answer is known.
  always_comb begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    leave_shift = (cnt_q == LAST_BIT) || !cell_nxt.eq;
`else
    leave_shift = (cnt_q == LAST_BIT);
`endif
  end

  // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    casc_d  = casc_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          casc_d  = normalise_casc(lt_in, eq_in, gt_in);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
        b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
        casc_d = cell_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (leave_shift) begin
          res_d   = cell_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      casc_q  <= '0;
      res_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      casc_q  <= casc_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign a_lt_b = res_q.lt;
  assign a_eq_b = res_q.eq;
  assign a_gt_b = res_q.gt;

endmodule
